vt_stream_arbiter: RTL and testbench

//  Multi-source byte front end for the VT100 parser: merges NUM_CH independent byte streams
//  (UART host, local keyboard echo, debug injector, ...) into the single data/dataReady stream

---
 rtl/vt_stream_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_vt_stream_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/vt_stream_arbiter.sv
// Multi-source byte front end for the VT100 parser: per-channel FIFOs, round-robin
// arbitration and an escape-sequence lock that keeps one source's ESC/CSI bytes contiguous.
module vt_stream_arbiter #(
    parameter int NUM_CH      = 2,
    parameter int FIFO_DEPTH  = 16,
    parameter int SEQ_TIMEOUT = 4096,
    parameter int MAX_SEQ_LEN = 32,
    localparam int CW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_CH-1:0]   in_valid,
    input  logic [8*NUM_CH-1:0] in_data,
    input  logic                parser_busy,
    output logic                dataReady,
    output logic [7:0]          data,
    output logic [CW-1:0]       data_ch,
    output logic [NUM_CH-1:0]   overflow,
    input  logic                overflow_clr,
    output logic                seq_abort,
    output logic [1:0]          lock_state
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(SEQ_TIMEOUT + 1);
    localparam int LW = $clog2(MAX_SEQ_LEN + 1);

    typedef enum logic [1:0] {S_IDLE, S_ESC, S_ESC_INT, S_CSI} lock_state_t;

    lock_state_t         state, nat_state;
    logic [CW-1:0]       lock_ch, rr, grant;
    logic [TW-1:0]       idle_cnt;
    logic [LW-1:0]       len;
    logic [7:0]          mem [NUM_CH][FIFO_DEPTH];
    logic [AW:0]         wr_ptr [NUM_CH];
    logic [AW:0]         rd_ptr [NUM_CH];
    logic [NUM_CH-1:0]   empty, full, pop_ch, wr_ok;
    logic [2*NUM_CH-1:0] ne2;
    logic [NUM_CH-1:0]   ne_rot;
    logic                grant_valid, pop;
    logic [7:0]          pop_byte;
    int                  g_off, g_int;

    assign lock_state = state;

    function automatic logic [CW-1:0] next_ch(input logic [CW-1:0] c);
        if (int'(c) >= NUM_CH - 1) return '0;
        return c + 1'b1;
    endfunction

    always_comb begin
        empty = '0;
        full  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            empty[c] = (wr_ptr[c] == rd_ptr[c]);
            full[c]  = (wr_ptr[c][AW] != rd_ptr[c][AW]) &&
                       (wr_ptr[c][AW-1:0] == rd_ptr[c][AW-1:0]);
        end
    end

    // Rotate the non-empty mask so bit 0 is the RR pointer; lowest set bit wins.
    always_comb begin
        ne2         = {~empty, ~empty} >> rr;
        ne_rot      = ne2[NUM_CH-1:0];
        g_off       = 0;
        g_int       = 0;
        grant       = '0;
        grant_valid = 1'b0;
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (ne_rot[j]) g_off = j;
        end
        if (state != S_IDLE) begin
            grant       = lock_ch;
            grant_valid = ~empty[lock_ch];
        end else begin
            grant_valid = |ne_rot;
            g_int       = int'(rr) + g_off;
            if (g_int >= NUM_CH) g_int = g_int - NUM_CH;
            grant = CW'(g_int);
        end
    end

    assign pop      = grant_valid && !parser_busy;
    assign pop_byte = mem[grant][rd_ptr[grant][AW-1:0]];

    always_comb begin
        pop_ch = '0;
        if (pop) pop_ch[grant] = 1'b1;
        wr_ok = in_valid & (~full | pop_ch);
    end

    // Sequence grammar applied to the byte being popped this cycle.
    always_comb begin
        nat_state = state;
        if (state == S_IDLE) begin
            if (pop_byte == 8'h1B) nat_state = S_ESC;
        end else if (state == S_ESC_INT || pop_byte == 8'h18 || pop_byte == 8'h1A) begin
            nat_state = S_IDLE;
        end else if (pop_byte == 8'h1B) begin
            nat_state = S_ESC;
        end else if (state == S_ESC) begin
            if (pop_byte == 8'h5B) nat_state = S_CSI;
            else if (pop_byte == 8'h28 || pop_byte == 8'h29 || pop_byte == 8'h23) nat_state = S_ESC_INT;
            else if (pop_byte >= 8'h30 && pop_byte <= 8'h7E) nat_state = S_IDLE;
        end else if (state == S_CSI) begin
            if (pop_byte >= 8'h40 && pop_byte <= 8'h7E) nat_state = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (wr_ok[c]) mem[c][wr_ptr[c][AW-1:0]] <= in_data[8*c +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
            end
            overflow <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_ok[c])  wr_ptr[c] <= wr_ptr[c] + 1'b1;
                if (pop_ch[c]) rd_ptr[c] <= rd_ptr[c] + 1'b1;
            end
            overflow <= (overflow & ~{NUM_CH{overflow_clr}}) | (in_valid & full & ~pop_ch);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            lock_ch   <= '0;
            rr        <= '0;
            len       <= '0;
            idle_cnt  <= '0;
            dataReady <= 1'b0;
            data      <= '0;
            data_ch   <= '0;
            seq_abort <= 1'b0;
        end else begin
            dataReady <= pop;
            seq_abort <= 1'b0;
            if (pop) begin
                data     <= pop_byte;
                data_ch  <= grant;
                idle_cnt <= '0;
                if (state == S_IDLE) begin
                    rr <= next_ch(grant);
                    if (nat_state == S_ESC) begin
                        state   <= S_ESC;
                        lock_ch <= grant;
                        len     <= LW'(1);
                    end
                end else if (nat_state == S_IDLE) begin
                    state <= S_IDLE;
                    rr    <= next_ch(lock_ch);
                end else if (nat_state == S_ESC && pop_byte == 8'h1B) begin
                    state <= S_ESC;
                    len   <= LW'(1);
                end else if (len >= LW'(MAX_SEQ_LEN - 1)) begin
                    state     <= S_IDLE;
                    rr        <= next_ch(lock_ch);
                    seq_abort <= 1'b1;
                end else begin
                    state <= nat_state;
                    len   <= len + 1'b1;
                end
            end else if (state != S_IDLE && !parser_busy) begin
                // Locked channel is empty here, otherwise it would have been popped.
                if (idle_cnt >= TW'(SEQ_TIMEOUT - 1)) begin
                    state     <= S_IDLE;
                    rr        <= next_ch(lock_ch);
                    idle_cnt  <= '0;
                    seq_abort <= 1'b1;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_vt_stream_arbiter.sv
// Bench for vt_stream_arbiter: scripted two-channel stimulus, expected {channel, byte}
// pairs queued as traffic is driven and matched against every dataReady strobe.
module tb_vt_stream_arbiter;
    localparam int NUM_CH      = 2;
    localparam int FIFO_DEPTH  = 16;
    localparam int SEQ_TIMEOUT = 64;
    localparam int MAX_SEQ_LEN = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  in_valid = '0;
    logic [15:0] in_data = '0;
    logic        parser_busy = 1'b0;
    logic        overflow_clr = 1'b0;
    logic        dataReady;
    logic [7:0]  data;
    logic [0:0]  data_ch;
    logic [1:0]  overflow;
    logic        seq_abort;
    logic [1:0]  lock_state;

    logic [8:0]  exp_q[$];
    int n_cmp = 0, n_err = 0;
    int cyc = 0, n_abort = 0, abort_cyc = 0, abort_base = 0;
    int last_cyc [2] = '{0, 0};

    vt_stream_arbiter #(
        .NUM_CH(NUM_CH), .FIFO_DEPTH(FIFO_DEPTH),
        .SEQ_TIMEOUT(SEQ_TIMEOUT), .MAX_SEQ_LEN(MAX_SEQ_LEN)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .parser_busy(parser_busy), .dataReady(dataReady), .data(data),
        .data_ch(data_ch), .overflow(overflow), .overflow_clr(overflow_clr),
        .seq_abort(seq_abort), .lock_state(lock_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (seq_abort) begin
                n_abort++;
                abort_cyc = cyc;
            end
            if (dataReady) begin
                last_cyc[data_ch] = cyc;
                if (exp_q.size() == 0) check("spurious_out", {31'd0, dataReady}, 32'd0);
                else check("out", {23'd0, data_ch, data}, {23'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic push(input logic ch, input logic [7:0] b);
        exp_q.push_back({ch, b});
    endtask

    task automatic drive(input logic [1:0] v, input logic [7:0] b0, input logic [7:0] b1);
        in_valid = v;
        in_data  = {b1, b0};
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = '0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_drain(input int max_cycles);
        int k = 0;
        in_valid = '0;
        while (exp_q.size() != 0 && k < max_cycles) begin
            @(negedge clk);
            k++;
        end
        check("drain", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] seq3 [6];
        logic [7:0] seq4 [8];
        seq3 = '{8'h1B, 8'h5B, 8'h31, 8'h3B, 8'h32, 8'h48};
        seq4 = '{8'h1B, 8'h5B, 8'h31, 8'h31, 8'h31, 8'h31, 8'h31, 8'h31};

        // Reset state
        #1 rst = 1'b1;
        #1;
        check("rst_ready", {31'd0, dataReady}, 0);
        check("rst_data", {24'd0, data}, 0);
        check("rst_ch", {31'd0, data_ch}, 0);
        check("rst_ovf", {30'd0, overflow}, 0);
        check("rst_abort", {31'd0, seq_abort}, 0);
        check("rst_state", {30'd0, lock_state}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Round robin interleave
        push(0, "A"); push(1, "x");
        push(0, "B"); push(1, "y");
        drive(2'b11, "A", "x");
        drive(2'b11, "B", "y");
        wait_drain(20);

        // CSI sequence on ch0 stays contiguous against ch1 traffic
        for (int i = 0; i < 6; i++) push(0, seq3[i]);
        for (int i = 0; i < 6; i++) push(1, "z");
        for (int i = 0; i < 6; i++) drive(2'b11, seq3[i], "z");
        wait_drain(40);
        check("csi_unlock", {30'd0, lock_state}, 0);

        // Length limit force-release
        abort_base = n_abort;
        for (int i = 0; i < 8; i++) push(0, seq4[i]);
        for (int i = 0; i < 3; i++) push(1, "k");
        for (int i = 0; i < 8; i++) drive((i < 3) ? 2'b11 : 2'b01, seq4[i], "k");
        wait_drain(40);
        check("len_abort", n_abort - abort_base, 1);
        check("len_unlock", {30'd0, lock_state}, 0);

        // Timeout force-release
        abort_base = n_abort;
        push(0, 8'h1B); push(0, "["); push(0, "3");
        push(1, "w"); push(1, "w");
        drive(2'b11, 8'h1B, "w");
        drive(2'b11, "[", "w");
        drive(2'b01, "3", 8'h00);
        wait_drain(SEQ_TIMEOUT + 40);
        check("to_abort", n_abort - abort_base, 1);
        check("to_gap", abort_cyc - last_cyc[0], SEQ_TIMEOUT);
        check("to_unlock", {30'd0, lock_state}, 0);

        // Overflow with parser stalled
        parser_busy = 1'b1;
        for (int i = 0; i < 17; i++) drive(2'b01, 8'h61 + 8'(i), 8'h00);
        idle(2);
        check("ovf_set", {30'd0, overflow}, 32'h1);
        check("busy_noready", {31'd0, dataReady}, 0);
        check("busy_hold", {23'd0, data_ch, data}, {23'd0, 1'b1, 8'h77});
        overflow_clr = 1'b1;
        drive(2'b01, 8'h7A, 8'h00);
        overflow_clr = 1'b0;
        idle(1);
        check("ovf_set_wins", {30'd0, overflow}, 32'h1);
        overflow_clr = 1'b1;
        idle(1);
        overflow_clr = 1'b0;
        check("ovf_clr", {30'd0, overflow}, 0);
        for (int i = 0; i < 16; i++) push(0, 8'h61 + 8'(i));
        parser_busy = 1'b0;
        wait_drain(40);

        // CAN inside CSI releases the lock; ch1 granted on the next cycle
        push(0, 8'h1B); push(0, "["); push(0, 8'h18); push(1, "c");
        drive(2'b01, 8'h1B, 8'h00);
        drive(2'b11, "[", "c");
        drive(2'b01, 8'h18, 8'h00);
        wait_drain(20);
        check("can_gap", last_cyc[1] - last_cyc[0], 1);
        check("can_unlock", {30'd0, lock_state}, 0);

        // Asynchronous reset in the middle of a CSI sequence
        parser_busy = 1'b1;
        drive(2'b11, 8'h1B, "r");
        drive(2'b11, "[", "s");
        drive(2'b11, "5", "t");
        in_valid = '0;
        push(0, 8'h1B); push(0, "[");
        parser_busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        parser_busy = 1'b1;
        @(negedge clk);
        check("pre_rst_state", {30'd0, lock_state}, 3);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_data", {24'd0, data}, 0);
        check("mid_rst_ready", {31'd0, dataReady}, 0);
        check("mid_rst_state", {30'd0, lock_state}, 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        parser_busy = 1'b0;
        @(negedge clk);
        push(0, "A"); push(1, "b");
        drive(2'b11, "A", "b");
        wait_drain(20);
        check("post_rst_state", {30'd0, lock_state}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
